// File: rtl/inert_spi_seq_pkg.sv
// Shared types and command words for the inertial-sensor SPI sequencer.
// Imported by the sequencer, its timer and anything decoding its state.
package inert_pkg;

  typedef enum logic [2:0] {
    PORW,
    CFG1,
    CFG2,
    CFG3,
    IDLE,
    RDL,
    RDH
  } state_e;

  localparam logic [15:0] CMD_CFG1 = 16'h0D02;
  localparam logic [15:0] CMD_CFG2 = 16'h1160;
  localparam logic [15:0] CMD_CFG3 = 16'h1440;
  localparam logic [15:0] CMD_RDL  = 16'hA600;
  localparam logic [15:0] CMD_RDH  = 16'hA700;
  localparam logic [15:0] CMD_NONE = 16'h0000;

  function automatic logic is_txn(state_e s);
    return !(s == PORW || s == IDLE);
  endfunction

endpackage

// File: rtl/inert_spi_seq_if.sv
// Command/response link between the sequencer and the SPI monarch.
// The sequencer is master; the monarch side uses the slave modport.
interface inert_spi_seq_if;

  logic        wrt;
  logic [15:0] cmd;
  logic        done;
  logic [7:0]  rd_byte;

  modport master (
    output wrt,
    output cmd,
    input  done,
    input  rd_byte
  );

  modport slave (
    input  wrt,
    input  cmd,
    output done,
    output rd_byte
  );

endinterface

// File: rtl/inert_spi_seq_por_timer.sv
// Power-on wait timer: counts while enabled, clears otherwise.
// tc is high while the count sits at all ones.
module por_timer #(
  parameter int POR_BITS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tc
);

  logic [POR_BITS-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + POR_BITS'(1);
    end else begin
      cnt <= '0;
    end
  end

  assign tc = &cnt;

endmodule

// File: rtl/inert_spi_seq.sv
// Inertial sensor sequencer: power-on wait, three config writes,
// then one yaw-rate read pair (low, high) per interrupt edge.
module inert_spi_seq
  import inert_pkg::*;
#(
  parameter int POR_BITS = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            INT,
  inert_spi_seq_if.master spi,
  output logic [15:0]     yaw_rt,
  output logic            vld
);

  state_e      state;
  state_e      nxt;
  state_e      prev;
  logic        tc;
  logic        int_s1;
  logic        int_s2;
  logic        int_s3;
  logic        int_rise;
  logic        done_q;
  logic        armed;
  logic        cmplt;
  logic [7:0]  lo_byte;

  por_timer #(
    .POR_BITS(POR_BITS)
  ) u_por (
    .clk  (clk),
    .rst_n(rst_n),
    .en   (state == PORW),
    .tc   (tc)
  );

  assign int_rise = int_s2 & ~int_s3;
  // Only a fresh done rise after our own wrt counts as completion.
  assign cmplt = spi.done & ~done_q & armed;

  always_comb begin
    nxt = state;
    case (state)
      PORW:    if (tc)       nxt = CFG1;
      CFG1:    if (cmplt)    nxt = CFG2;
      CFG2:    if (cmplt)    nxt = CFG3;
      CFG3:    if (cmplt)    nxt = IDLE;
      IDLE:    if (int_rise) nxt = RDL;
      RDL:     if (cmplt)    nxt = RDH;
      RDH:     if (cmplt)    nxt = IDLE;
      default:               nxt = PORW;
    endcase
  end

  always_comb begin
    spi.cmd = CMD_NONE;
    unique case (1'b1)
      (state == CFG1): spi.cmd = CMD_CFG1;
      (state == CFG2): spi.cmd = CMD_CFG2;
      (state == CFG3): spi.cmd = CMD_CFG3;
      (state == RDL):  spi.cmd = CMD_RDL;
      (state == RDH):  spi.cmd = CMD_RDH;
      default:         spi.cmd = CMD_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= PORW;
      prev    <= PORW;
      int_s1  <= 1'b0;
      int_s2  <= 1'b0;
      int_s3  <= 1'b0;
      done_q  <= 1'b0;
      armed   <= 1'b0;
      spi.wrt <= 1'b0;
      lo_byte <= 8'h00;
      yaw_rt  <= 16'h0000;
      vld     <= 1'b0;
    end else begin
      state   <= nxt;
      prev    <= state;
      int_s1  <= INT;
      int_s2  <= int_s1;
      int_s3  <= int_s2;
      done_q  <= spi.done;
      armed   <= spi.wrt | (armed & ~cmplt);
      spi.wrt <= is_txn(state) && (state != prev);
      vld     <= 1'b0;
      if (state == RDL && cmplt) begin
        lo_byte <= spi.rd_byte;
      end
      if (state == RDH && cmplt) begin
        yaw_rt <= {spi.rd_byte, lo_byte};
        vld    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_inert_spi_seq.sv
// Directed bench for inert_spi_seq with a small SPI monarch responder.
// Read pairs come from a vector table; corner cases are hand sequences.
module tb_inert_spi_seq;

  typedef struct {
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [15:0] yaw;
  } rd_vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        int_in = 1'b0;
  logic [15:0] yaw_rt;
  logic        vld;

  logic        auto_resp = 1'b1;
  logic        resp_done = 1'b0;
  logic        man_done = 1'b0;
  logic [7:0]  resp_byte = 8'h00;
  int          resp_lat = 3;
  logic [7:0]  resp_q[$];

  logic [15:0] cmd_log[$];
  int          wrt_cnt = 0;
  int          vld_cnt = 0;
  int          consec = 0;
  logic        prev_wrt = 1'b0;
  logic [15:0] last_yaw = 16'h0000;

  int          n_cmp = 0;
  int          n_bad = 0;

  inert_spi_seq_if spi();

  assign spi.done    = auto_resp ? resp_done : man_done;
  assign spi.rd_byte = resp_byte;

  inert_spi_seq #(
    .POR_BITS(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .INT   (int_in),
    .spi   (spi),
    .yaw_rt(yaw_rt),
    .vld   (vld)
  );

  always #5 clk = ~clk;

  // SPI monarch model: drop done on wrt, raise it with data later.
  always begin
    @(posedge clk);
    #1;
    if (auto_resp && spi.wrt === 1'b1) begin
      resp_done = 1'b0;
      for (int k = 0; k < resp_lat && rst_n; k++) @(posedge clk);
      #1;
      if (rst_n) begin
        if ((spi.cmd == 16'hA600 || spi.cmd == 16'hA700) && resp_q.size() > 0)
          resp_byte = resp_q.pop_front();
        resp_done = 1'b1;
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (spi.wrt === 1'b1) begin
      cmd_log.push_back(spi.cmd);
      wrt_cnt++;
      if (prev_wrt) consec++;
    end
    prev_wrt = spi.wrt;
    if (vld === 1'b1) begin
      vld_cnt++;
      last_yaw = yaw_rt;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic wait_cmd(input logic [15:0] v, input int budget, input string nm);
    for (int k = 0; k < budget && spi.cmd !== v; k++) @(negedge clk);
    chk(nm, {16'h0, spi.cmd}, {16'h0, v});
  endtask

  task automatic pulse_int();
    @(negedge clk);
    int_in = 1'b1;
    repeat (3) @(negedge clk);
    int_in = 1'b0;
  endtask

  task automatic por_check(input string nm);
    int cyc;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (spi.wrt === 1'b1) break;
    end
    n_cmp++;
    if (cyc < 16 || cyc > 18) begin
      n_bad++;
      $display("FAIL %s: got %0d cycles, want 17+-1", nm, cyc);
    end
    chk({nm, "_cmd"}, {16'h0, spi.cmd}, 32'h0D02);
  endtask

  task automatic do_read(input logic [7:0] lo, input logic [7:0] hi,
                         input logic [15:0] exp, input string nm);
    int n0;
    int v0;
    int k;
    n0 = cmd_log.size();
    v0 = vld_cnt;
    resp_q.push_back(lo);
    resp_q.push_back(hi);
    pulse_int();
    for (k = 0; k < 100 && vld_cnt == v0; k++) @(negedge clk);
    repeat (20) @(negedge clk);
    chk({nm, "_yaw"}, {16'h0, yaw_rt}, {16'h0, exp});
    chk({nm, "_vld_yaw"}, {16'h0, last_yaw}, {16'h0, exp});
    chk({nm, "_vld_cnt"}, vld_cnt - v0, 1);
    chk({nm, "_ncmd"}, cmd_log.size() - n0, 2);
    if (cmd_log.size() >= n0 + 2) begin
      chk({nm, "_cmd_lo"}, {16'h0, cmd_log[n0]}, 32'hA600);
      chk({nm, "_cmd_hi"}, {16'h0, cmd_log[n0+1]}, 32'hA700);
    end
  endtask

  rd_vec_t tbl[5];

  initial begin
    int n0;
    int v0;
    int w0;

    tbl[0] = '{lo: 8'h34, hi: 8'h12, yaw: 16'h1234};
    tbl[1] = '{lo: 8'h00, hi: 8'h80, yaw: 16'h8000};
    tbl[2] = '{lo: 8'hFF, hi: 8'hFF, yaw: 16'hFFFF};
    tbl[3] = '{lo: 8'h01, hi: 8'h00, yaw: 16'h0001};
    tbl[4] = '{lo: 8'hA5, hi: 8'h7F, yaw: 16'h7FA5};

    repeat (3) @(negedge clk);
    chk("rst_yaw", {16'h0, yaw_rt}, 32'h0);
    chk("rst_vld", {31'h0, vld}, 32'h0);
    chk("rst_wrt", {31'h0, spi.wrt}, 32'h0);
    chk("rst_cmd", {16'h0, spi.cmd}, 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    por_check("por1");
    wait_cmd(16'h0000, 200, "cfg_to_idle");
    chk("cfg_ncmd", cmd_log.size(), 3);
    if (cmd_log.size() >= 3) begin
      chk("cfg1_cmd", {16'h0, cmd_log[0]}, 32'h0D02);
      chk("cfg2_cmd", {16'h0, cmd_log[1]}, 32'h1160);
      chk("cfg3_cmd", {16'h0, cmd_log[2]}, 32'h1440);
    end

    for (int i = 0; i < 5; i++) begin
      do_read(tbl[i].lo, tbl[i].hi, tbl[i].yaw, $sformatf("vec%0d", i));
    end

    // INT edge while the high-byte read is in flight must be dropped.
    resp_lat = 10;
    n0 = cmd_log.size();
    v0 = vld_cnt;
    resp_q.push_back(8'h56);
    resp_q.push_back(8'h78);
    pulse_int();
    wait_cmd(16'hA700, 100, "rdh_enter");
    pulse_int();
    repeat (60) @(negedge clk);
    chk("drop_ncmd", cmd_log.size() - n0, 2);
    chk("drop_vld_cnt", vld_cnt - v0, 1);
    chk("drop_yaw", {16'h0, yaw_rt}, 32'h7856);
    resp_lat = 3;
    do_read(8'h9A, 8'hBC, 16'hBC9A, "after_drop");

    // Asynchronous reset in the middle of a low-byte read.
    resp_q.push_back(8'h11);
    resp_q.push_back(8'h22);
    pulse_int();
    wait_cmd(16'hA600, 100, "rdl_enter");
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_yaw", {16'h0, yaw_rt}, 32'h0);
    chk("mid_rst_vld", {31'h0, vld}, 32'h0);
    chk("mid_rst_wrt", {31'h0, spi.wrt}, 32'h0);
    chk("mid_rst_cmd", {16'h0, spi.cmd}, 32'h0);
    resp_q.delete();

    // Manual done: a stale-high done must never complete a command.
    auto_resp = 1'b0;
    man_done = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    por_check("por2");
    @(negedge clk);
    w0 = wrt_cnt;
    man_done = 1'b0;
    repeat (3) @(negedge clk);
    man_done = 1'b1;
    wait_cmd(16'h1160, 20, "man_cfg2");
    repeat (20) @(negedge clk);
    chk("stale_hold_cmd", {16'h0, spi.cmd}, 32'h1160);
    chk("stale_hold_wrt", wrt_cnt - w0, 1);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    man_done = 1'b1;
    wait_cmd(16'h1440, 20, "man_cfg3");
    repeat (3) @(negedge clk);
    man_done = 1'b0;
    repeat (2) @(negedge clk);
    man_done = 1'b1;
    wait_cmd(16'h0000, 20, "man_idle");
    auto_resp = 1'b1;
    repeat (2) @(negedge clk);
    do_read(8'h34, 8'h12, 16'h1234, "post_rst");

    chk("no_b2b_wrt", consec, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/inert_spi_seq.md
INERT_SPI_SEQ -- requirements
Module: inert_spi_seq

Interface
REQ-001 Parameter: POR_BITS, default 16, width of the power-on wait timer; the wait lasts 2^POR_BITS clk cycles.
REQ-002 clk  input  1  system clock; all state advances on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 INT  input  1  data-ready interrupt from the inertial sensor; asynchronous to clk.
REQ-005 wrt  output  1  one-cycle pulse that starts an SPI transaction.
REQ-006 cmd  output  16  command word driven to the SPI monarch's wt_data.
REQ-007 done  input  1  SPI transaction complete; level, stays high until the next wrt.
REQ-008 rd_byte  input  8  low byte of the SPI monarch's rd_data.
REQ-009 yaw_rt  output  16  latest assembled yaw-rate sample, two's complement.
REQ-010 vld  output  1  one-cycle pulse when yaw_rt has been updated.

Function
REQ-011 The block SHALL sequence the following phases in order: power-on wait; three configuration writes; then an endless loop that reads yaw on each interrupt.
REQ-012 The FSM states SHALL be PORW, CFG1, CFG2, CFG3, IDLE, RDL, RDH.
REQ-013 PORW: the POR_BITS-bit timer SHALL increment from 0 each cycle; on terminal count (all ones) the FSM SHALL go to CFG1.
REQ-014 Each CFGn/RDx state SHALL pulse wrt for exactly one cycle on entry, holding cmd stable from that cycle until the state exits.
REQ-015 cmd values SHALL be: CFG1 0x0D02, CFG2 0x1160, CFG3 0x1440, RDL 0xA600, RDH 0xA700.
REQ-016 The completion event SHALL be the rising edge of done (done high, registered done low); a stale high done SHALL NOT complete a transaction.
REQ-017 Transitions on completion event: CFG1->CFG2->CFG3->IDLE, RDL->RDH, RDH->IDLE.
REQ-018 INT SHALL pass through a two-flop synchronizer; IDLE->RDL SHALL fire on the rising edge of the synchronized INT.
REQ-019 An INT edge arriving outside IDLE SHALL be dropped, not queued.
REQ-020 On RDL completion, rd_byte SHALL be captured into a low-byte holding register.
REQ-021 On RDH completion, yaw_rt SHALL load {rd_byte, held low byte} on the next edge, and vld SHALL be high for that same single cycle.
REQ-022 yaw_rt SHALL hold its value between updates.
REQ-023 The cmd default SHALL be 0x0000 in PORW and IDLE.
REQ-024 Latency: wrt SHALL assert the cycle after the FSM enters a transaction state, and never on two consecutive cycles.

Reset
REQ-025 Asynchronous rst_n low SHALL force the following, mid-transaction included: state PORW, timer 0, wrt 0, vld 0, yaw_rt 0x0000, held low byte 0x00, synchronizer flops 0, registered done 0.
REQ-026 After reset release, the first wrt SHALL occur no earlier than 2^POR_BITS cycles later.

Structure
REQ-027 The state enum and the five command constants SHALL reside in shared package inert_pkg.
REQ-028 The timer SHALL be a sub-module por_timer (parameter POR_BITS, outputs terminal count).
REQ-029 The SPI monarch SHALL be instantiated by the parent; this block SHALL NOT contain SPI shift logic.

Verification
REQ-030 POR_BITS=4, release reset -> wrt first pulses 17±1 cycles later with cmd=0x0D02; CFG sequence 0x0D02, 0x1160, 0x1440, each wrt following the prior done rise.
REQ-031 Hold done high continuously after CFG1 completes -> no advance past CFG2 until done falls and rises again.
REQ-032 In IDLE, assert INT; serf returns 0x34 then 0x12 -> yaw_rt=0x1234, vld single pulse, cmds 0xA600 then 0xA700.
REQ-033 Pulse INT during RDH -> no additional read; a subsequent INT edge in IDLE -> exactly one new read pair.
REQ-034 Assert rst_n low during RDL -> yaw_rt=0x0000, vld=0, wrt=0 immediately; power-on wait restarts.
REQ-035 Negative sample: serf returns 0x00 then 0x80 -> yaw_rt=0x8000.
